mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_load_align.sv | 16 +
 rtl/mem_stage.sv | 61 ++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, mem_op bit positions, stall levels, FSM encoding and the EX->MEM bus layout
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 81;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_FWD_WD = 38;
  localparam int STALL_BUS_WD = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int OP_LB = 4;
  localparam int OP_LBU = 3;
  localparam int OP_LH = 2;
  localparam int OP_LHU = 1;
  localparam int OP_LW = 0;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} mem_state_e;
  typedef struct packed {
    logic [4:0] mem_op;
    logic [31:0] pc;
    logic ram_en;
    logic [3:0] ram_wen;
    logic sel_rf_res;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-facing signals of the MEM stage; mem_excp exists only when MEM_ALIGN_CHECK_EN is defined
interface mem_stage_if import mem_stage_pkg::*; ();
  logic flush;
  logic [STALL_BUS_WD-1:0] stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic data_sram_rvalid;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_FWD_WD-1:0] mem_to_id_fwd;
  logic stall_for_mem;
`ifdef MEM_ALIGN_CHECK_EN
  logic mem_excp;
`endif
  modport master (
    output flush, stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
`ifdef MEM_ALIGN_CHECK_EN
    input mem_excp,
`endif
    input mem_to_wb_bus, mem_to_id_fwd, stall_for_mem
  );
  modport slave (
    input flush, stall, ex_to_mem_bus, data_sram_rdata, data_sram_rvalid,
`ifdef MEM_ALIGN_CHECK_EN
    output mem_excp,
`endif
    output mem_to_wb_bus, mem_to_id_fwd, stall_for_mem
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half/word of a load and sign/zero extends it
module load_align import mem_stage_pkg::*; (
  input logic [4:0] mem_op,
  input logic [1:0] offset,
  input logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = offset[1] ? (offset[0] ? rdata[31:24] : rdata[23:16]) : (offset[0] ? rdata[15:8] : rdata[7:0]);
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];
  assign data = mem_op[OP_LB] ? {{24{b[7]}}, b} :
                mem_op[OP_LBU] ? {24'b0, b} :
                mem_op[OP_LH] ? {{16{h[15]}}, h} :
                mem_op[OP_LHU] ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with load-data wait/hold FSM; MEM_ALIGN_CHECK_EN adds misaligned-load trapping
module mem_stage import mem_stage_pkg::*; (
  input logic clk,
  input logic resetn,
  mem_stage_if.slave bus
);
  ex_to_mem_t r;
  mem_state_e st, st_nx;
  logic [31:0] rdata_buf, ld_data, rf_wdata;
  logic drop, adv, is_ld, ld, pending, rv, rf_we;
  assign is_ld = (|r.mem_op) & r.ram_en & ~(|r.ram_wen);
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = is_ld & (((r.mem_op[OP_LH] | r.mem_op[OP_LHU]) & r.ex_result[0]) | (r.mem_op[OP_LW] & (|r.ex_result[1:0])));
  assign ld = is_ld & ~misalign;
  assign rf_we = r.rf_we & ~misalign;
  assign bus.mem_excp = misalign;
`else
  assign ld = is_ld;
  assign rf_we = r.rf_we;
`endif
  // the input register changes whenever it is flushed, refilled or bubbled
  assign adv = bus.flush | (bus.stall[3] == NO_STOP) | (bus.stall[4] == NO_STOP);
  // a response for a flushed load is swallowed rather than given to the next load
  assign rv = bus.data_sram_rvalid & ~drop;
  assign pending = (st == S_WAIT) | ((st == S_IDLE) & ld);
  // EX->MEM register: load on advance, bubble on flush or when only WB moves on
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r <= '0;
    else if (bus.flush || (bus.stall[3] == STOP && bus.stall[4] == NO_STOP)) r <= '0;
    else if (bus.stall[3] == NO_STOP) r <= bus.ex_to_mem_bus;
  // FSM state, captured load word and the discard flag for an orphaned response
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= S_IDLE;
      rdata_buf <= '0;
      drop <= 1'b0;
    end else begin
      st <= st_nx;
      if (pending && rv) rdata_buf <= bus.data_sram_rdata;
      drop <= (bus.flush & pending & ~rv) | (drop & ~bus.data_sram_rvalid);
    end
  // next state: data arriving while the register holds must be parked in HOLD
  always_comb begin
    st_nx = bus.flush ? S_IDLE :
            st == S_HOLD ? (adv ? S_IDLE : S_HOLD) :
            !pending ? S_IDLE :
            !rv ? S_WAIT :
            adv ? S_IDLE : S_HOLD;
    bus.stall_for_mem = pending & ~rv;
  end
  load_align u_align (
    .mem_op(r.mem_op),
    .offset(r.ex_result[1:0]),
    .rdata(st == S_HOLD ? rdata_buf : bus.data_sram_rdata),
    .data(ld_data)
  );
  assign rf_wdata = r.sel_rf_res ? ld_data : r.ex_result;
  assign bus.mem_to_wb_bus = {r.pc, rf_we, r.rf_waddr, rf_wdata};
  assign bus.mem_to_id_fwd = {rf_we, r.rf_waddr, rf_wdata};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage; honours MEM_ALIGN_CHECK_EN
module tb_mem_stage;
  import mem_stage_pkg::*;
  localparam logic [5:0] RUN = 6'b000000;
  localparam logic [5:0] HALT = 6'b011111;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc, input logic en,
    input logic [3:0] wen, input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      5'b10000: return b - ((b & 32'h80) << 1);
      5'b01000: return b;
      5'b00100: return h - ((h & 32'h8000) << 1);
      5'b00010: return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] d,
    input logic [31:0] pc, input logic sfm);
    chk({tag, "_wb"}, bus.mem_to_wb_bus, {pc, we, wa, d});
    chk({tag, "_fwd"}, 70'(bus.mem_to_id_fwd), 70'({we, wa, d}));
    chk({tag, "_sfm"}, 70'(bus.stall_for_mem), 70'(sfm));
  endtask

  task automatic drive(input logic [80:0] ex, input logic [5:0] s, input logic v, input logic [31:0] rd, input logic fl);
    bus.ex_to_mem_bus = ex;
    bus.stall = s;
    bus.data_sram_rvalid = v;
    bus.data_sram_rdata = rd;
    bus.flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int kind, d, h;
    logic [4:0] op, wa;
    logic [31:0] pc, addr, w, exp;
    logic mis;
    drive('0, RUN, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    out("reset", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    resetn = 1'b1;
    // lb at byte 3 with data in the same cycle
    drive(mk(5'b10000, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h1003), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, RUN, 1'b1, 32'h80FF1234, 1'b0);
    #2;
    out("lb_b3", 1'b1, 5'd5, 32'hFFFFFF80, 32'h100, 1'b0);
    tick;
    // lhu at offset 2 with three wait cycles
    drive(mk(5'b00010, 32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h2002), RUN, 1'b0, '0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive('0, HALT, 1'b0, $urandom, 1'b0);
      #2;
      chk("lhu_wait_sfm", 70'(bus.stall_for_mem), 70'(1));
      tick;
    end
    drive('0, RUN, 1'b1, 32'h80010000, 1'b0);
    #2;
    out("lhu_off2", 1'b1, 5'd6, 32'h00008001, 32'h200, 1'b0);
    tick;
    drive('0, RUN, 1'b0, '0, 1'b0);
    #2;
    out("bubble", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick;
    // lw whose data arrives while WB is stalled, then held
    drive(mk(5'b00001, 32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h3000), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b1, 32'h11223344, 1'b0);
    #2;
    out("lw_hit", 1'b1, 5'd7, 32'h11223344, 32'h300, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive('0, i == 2 ? RUN : HALT, 1'b0, 32'hDEADBEEF, 1'b0);
      #2;
      out("lw_hold", 1'b1, 5'd7, 32'h11223344, 32'h300, 1'b0);
      tick;
    end
    drive(mk(5'b00001, 32'h304, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h3004), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, RUN, 1'b1, 32'hCAFEF00D, 1'b0);
    #2;
    out("lw_after_hold", 1'b1, 5'd7, 32'hCAFEF00D, 32'h304, 1'b0);
    tick;
    // flush during WAIT, late response next cycle
    drive(mk(5'b00001, 32'h400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h4000), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b0, '0, 1'b1);
    #2;
    chk("flush_wait_sfm", 70'(bus.stall_for_mem), 70'(1));
    tick;
    drive('0, RUN, 1'b1, 32'h55555555, 1'b0);
    #2;
    out("flush_late_rv", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick;
    // flushed response arriving while a new load is already in MEM
    drive(mk(5'b00001, 32'h500, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h5000), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b0, '0, 1'b1);
    tick;
    drive(mk(5'b01000, 32'h504, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h5001), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b1, 32'hAAAAAAAA, 1'b0);
    #2;
    chk("stale_rv_dropped", 70'(bus.stall_for_mem), 70'(1));
    tick;
    drive('0, RUN, 1'b1, 32'h0000C300, 1'b0);
    #2;
    out("lbu_after_flush", 1'b1, 5'd10, 32'h000000C3, 32'h504, 1'b0);
    tick;
    // reset in the middle of WAIT
    drive(mk(5'b00001, 32'h600, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h6000), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, HALT, 1'b0, '0, 1'b0);
    tick;
    resetn = 1'b0;
    #1;
    out("reset_mid_wait", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick;
    resetn = 1'b1;
    drive(mk(5'b00000, 32'h700, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h1234), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, RUN, 1'b0, '0, 1'b0);
    #2;
    out("addu_after_reset", 1'b1, 5'd3, 32'h1234, 32'h700, 1'b0);
    tick;
    // misaligned word load
    drive(mk(5'b00001, 32'h900, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h9002), RUN, 1'b0, '0, 1'b0);
    tick;
`ifdef MEM_ALIGN_CHECK_EN
    drive('0, RUN, 1'b0, '0, 1'b0);
    #2;
    chk("lw_mis_excp", 70'(bus.mem_excp), 70'(1));
    chk("lw_mis_we", 70'(bus.mem_to_wb_bus[37]), 70'(0));
    chk("lw_mis_sfm", 70'(bus.stall_for_mem), 70'(0));
    tick;
    drive('0, RUN, 1'b0, '0, 1'b0);
    #2;
    chk("excp_clear", 70'(bus.mem_excp), 70'(0));
`else
    drive('0, RUN, 1'b1, 32'h89ABCDEF, 1'b0);
    #2;
    out("lw_mis_trunc", 1'b1, 5'd12, 32'h89ABCDEF, 32'h900, 1'b0);
    tick;
    drive(mk(5'b00100, 32'h904, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h9003), RUN, 1'b0, '0, 1'b0);
    tick;
    drive('0, RUN, 1'b1, 32'h80001111, 1'b0);
    #2;
    out("lh_mis_trunc", 1'b1, 5'd13, 32'hFFFF8000, 32'h904, 1'b0);
`endif
    tick;
    // randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      pc = $urandom;
      addr = $urandom;
      w = $urandom;
      wa = 5'($urandom);
      if (kind != 2) begin
        drive(kind == 0 ? mk(5'b0, pc, 1'b0, 4'h0, 1'b0, 1'b1, wa, addr)
                        : mk(5'b0, pc, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0, wa, addr), RUN, 1'b0, '0, 1'b0);
        tick;
        drive('0, RUN, 1'($urandom_range(0, 1)), $urandom, 1'b0);
        #2;
        out("rnd_pass", kind == 0, wa, addr, pc, 1'b0);
        tick;
      end else begin
        op = 5'b00001 << $urandom_range(0, 4);
        exp = ref_load(op, addr[1:0], w);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((op == 5'b00100 || op == 5'b00010) && addr[0]) || (op == 5'b00001 && addr[1:0] != 2'd0);
`endif
        d = $urandom_range(0, 3);
        h = $urandom_range(0, 2);
        drive(mk(op, pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr), RUN, 1'b0, '0, 1'b0);
        tick;
        if (mis) begin
          drive('0, RUN, 1'b0, '0, 1'b0);
          #2;
          chk("rnd_mis_we", 70'(bus.mem_to_wb_bus[37]), 70'(0));
          chk("rnd_mis_sfm", 70'(bus.stall_for_mem), 70'(0));
          tick;
        end else begin
          for (int i = 0; i < d; i++) begin
            drive('0, HALT, 1'b0, $urandom, 1'b0);
            #2;
            chk("rnd_wait_sfm", 70'(bus.stall_for_mem), 70'(1));
            tick;
          end
          drive('0, h > 0 ? HALT : RUN, 1'b1, w, 1'b0);
          #2;
          out("rnd_load", 1'b1, wa, exp, pc, 1'b0);
          tick;
          for (int i = 0; i < h; i++) begin
            drive('0, i == h - 1 ? RUN : HALT, 1'b0, $urandom, 1'b0);
            #2;
            out("rnd_hold", 1'b1, wa, exp, pc, 1'b0);
            tick;
          end
        end
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
